// File: rtl/lru_replacement_controller.sv
// -----------------------------------------------------------------------------
// lru_replacement_controller
//
// Purpose:
//   Sequences cache-miss replacement and hit recency updates around an external
//   per-set LRU tracker. After reset it sweeps every set index with lru_reset
//   asserted, so the tracker can initialise its per-set order. It then accepts
//   one request at a time. A miss picks a victim way (an invalid way first,
//   else the tracker's LRU way), writes the victim back if it is dirty, waits
//   for the refill, and reports the new way to the tracker. A hit only reports
//   its way to the tracker.
//
// Ports:
//   clock, reset            single clock; synchronous active-high reset
//   miss_req/_index         miss request, set index; accepted when miss_ready=1
//   valid_bits, dirty_bits  per-way state of the missing set, sampled with miss
//   miss_ready              high when a miss can be accepted (IDLE only)
//   hit_req/_index/_way     hit recency update; accepted when hit_ready=1
//   hit_ready               high in IDLE when no miss is requested
//   lru_index, lru_reset    set index / order-init strobe to the LRU tracker
//   lru_way                 one-hot LRU vector, valid one cycle after lru_index
//   lru_access(_valid)      recency update to the tracker
//   wb_req/_way, wb_done    writeback handshake for a dirty victim
//   fill_req/_way, fill_done refill handshake for the victim way
//   victim_way              selected victim, stable until the next miss
//   miss_done, hit_done     one-cycle completion pulses
// -----------------------------------------------------------------------------
module lru_replacement_controller #(
  parameter int WIDTH      = 4,
  parameter int INDEX_BITS = 8,
  localparam int WAY_BITS  = $clog2(WIDTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  miss_req,
  input  logic [INDEX_BITS-1:0] miss_index,
  input  logic [WIDTH-1:0]      valid_bits,
  input  logic [WIDTH-1:0]      dirty_bits,
  output logic                  miss_ready,
  input  logic                  hit_req,
  input  logic [INDEX_BITS-1:0] hit_index,
  input  logic [WAY_BITS-1:0]   hit_way,
  output logic                  hit_ready,
  output logic [INDEX_BITS-1:0] lru_index,
  output logic                  lru_reset,
  input  logic [WIDTH-1:0]      lru_way,
  output logic [WAY_BITS-1:0]   lru_access,
  output logic                  lru_access_valid,
  output logic                  wb_req,
  output logic [WAY_BITS-1:0]   wb_way,
  input  logic                  wb_done,
  output logic                  fill_req,
  output logic [WAY_BITS-1:0]   fill_way,
  input  logic                  fill_done,
  output logic [WAY_BITS-1:0]   victim_way,
  output logic                  miss_done,
  output logic                  hit_done
);

  typedef enum logic [2:0] {
    INIT      = 3'd0,
    IDLE      = 3'd1,
    READ      = 3'd2,
    SELECT    = 3'd3,
    WRITEBACK = 3'd4,
    FILL      = 3'd5,
    UPDATE    = 3'd6
  } state_t;

  state_t                state_q,    state_d;
  logic [INDEX_BITS-1:0] init_cnt_q, init_cnt_d;
  logic [INDEX_BITS-1:0] index_q,    index_d;
  logic [WAY_BITS-1:0]   way_q,      way_d;
  logic [WIDTH-1:0]      valid_q,    valid_d;
  logic [WIDTH-1:0]      dirty_q,    dirty_d;
  logic                  is_hit_q,   is_hit_d;
  logic [WAY_BITS-1:0]   victim_q,   victim_d;

  // Victim candidate computed from the latched valid bits and the tracker's
  // LRU vector; only meaningful in SELECT, where lru_way is valid.
  logic [WAY_BITS-1:0]   victim_sel;
  logic                  victim_found;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      index_q    <= '0;
      way_q      <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      is_hit_q   <= 1'b0;
      victim_q   <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      index_q    <= index_d;
      way_q      <= way_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      is_hit_q   <= is_hit_d;
      victim_q   <= victim_d;
    end
  end

  // Lowest invalid way wins; failing that, lowest set bit of lru_way; a zero
  // LRU vector falls back to way 0.
  always_comb begin
    victim_sel   = '0;
    victim_found = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!victim_found && !valid_q[i]) begin
        victim_sel   = WAY_BITS'(i);
        victim_found = 1'b1;
      end
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (!victim_found && lru_way[i]) begin
        victim_sel   = WAY_BITS'(i);
        victim_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    init_cnt_d       = init_cnt_q;
    index_d          = index_q;
    way_d            = way_q;
    valid_d          = valid_q;
    dirty_d          = dirty_q;
    is_hit_d         = is_hit_q;
    victim_d         = victim_q;

    miss_ready       = 1'b0;
    hit_ready        = 1'b0;
    lru_index        = '0;
    lru_reset        = 1'b0;
    lru_access       = '0;
    lru_access_valid = 1'b0;
    wb_req           = 1'b0;
    wb_way           = '0;
    fill_req         = 1'b0;
    fill_way         = '0;
    victim_way       = victim_q;
    miss_done        = 1'b0;
    hit_done         = 1'b0;

    case (state_q)
      INIT: begin
        lru_reset  = 1'b1;
        lru_index  = init_cnt_q;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == {INDEX_BITS{1'b1}}) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        miss_ready = 1'b1;
        // A simultaneous miss takes priority, so the hit is not acknowledged.
        hit_ready  = !miss_req;
        if (miss_req) begin
          index_d  = miss_index;
          valid_d  = valid_bits;
          dirty_d  = dirty_bits;
          is_hit_d = 1'b0;
          state_d  = READ;
        end else if (hit_req) begin
          index_d  = hit_index;
          way_d    = hit_way;
          is_hit_d = 1'b1;
          state_d  = READ;
        end
      end
      READ: begin
        lru_index = index_q;
        state_d   = is_hit_q ? UPDATE : SELECT;
      end
      SELECT: begin
        lru_index = index_q;
        victim_d  = victim_sel;
        state_d   = (valid_q[victim_sel] && dirty_q[victim_sel]) ? WRITEBACK : FILL;
      end
      WRITEBACK: begin
        lru_index = index_q;
        wb_req    = 1'b1;
        wb_way    = victim_q;
        if (wb_done) begin
          state_d = FILL;
        end
      end
      FILL: begin
        lru_index = index_q;
        fill_req  = 1'b1;
        fill_way  = victim_q;
        if (fill_done) begin
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        lru_index        = index_q;
        lru_access_valid = 1'b1;
        lru_access       = is_hit_q ? way_q : victim_q;
        miss_done        = !is_hit_q;
        hit_done         = is_hit_q;
        state_d          = IDLE;
      end
      default: begin
        state_d = INIT;
      end
    endcase

    // Reset overrides the outputs immediately so an interrupted handshake
    // drops in the same cycle reset is seen.
    if (reset) begin
      miss_ready       = 1'b0;
      hit_ready        = 1'b0;
      lru_index        = '0;
      lru_reset        = 1'b1;
      lru_access       = '0;
      lru_access_valid = 1'b0;
      wb_req           = 1'b0;
      wb_way           = '0;
      fill_req         = 1'b0;
      fill_way         = '0;
      victim_way       = '0;
      miss_done        = 1'b0;
      hit_done         = 1'b0;
    end
  end

endmodule

// File: tb/tb_lru_replacement_controller.sv
module tb_lru_replacement_controller;

  localparam int WIDTH      = 4;
  localparam int INDEX_BITS = 4;
  localparam int WAY_BITS   = 2;
  localparam int DEPTH      = 16;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  miss_req;
  logic [INDEX_BITS-1:0] miss_index;
  logic [WIDTH-1:0]      valid_bits;
  logic [WIDTH-1:0]      dirty_bits;
  logic                  miss_ready;
  logic                  hit_req;
  logic [INDEX_BITS-1:0] hit_index;
  logic [WAY_BITS-1:0]   hit_way;
  logic                  hit_ready;
  logic [INDEX_BITS-1:0] lru_index;
  logic                  lru_reset;
  logic [WIDTH-1:0]      lru_way;
  logic [WAY_BITS-1:0]   lru_access;
  logic                  lru_access_valid;
  logic                  wb_req;
  logic [WAY_BITS-1:0]   wb_way;
  logic                  wb_done;
  logic                  fill_req;
  logic [WAY_BITS-1:0]   fill_way;
  logic                  fill_done;
  logic [WAY_BITS-1:0]   victim_way;
  logic                  miss_done;
  logic                  hit_done;

  int n_cmp = 0;
  int n_err = 0;
  int last_victim = 0;

  lru_replacement_controller #(.WIDTH(WIDTH), .INDEX_BITS(INDEX_BITS)) dut (
    .clock(clock), .reset(reset),
    .miss_req(miss_req), .miss_index(miss_index),
    .valid_bits(valid_bits), .dirty_bits(dirty_bits), .miss_ready(miss_ready),
    .hit_req(hit_req), .hit_index(hit_index), .hit_way(hit_way), .hit_ready(hit_ready),
    .lru_index(lru_index), .lru_reset(lru_reset), .lru_way(lru_way),
    .lru_access(lru_access), .lru_access_valid(lru_access_valid),
    .wb_req(wb_req), .wb_way(wb_way), .wb_done(wb_done),
    .fill_req(fill_req), .fill_way(fill_way), .fill_done(fill_done),
    .victim_way(victim_way), .miss_done(miss_done), .hit_done(hit_done)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference victim choice: collect candidates in order of preference.
  function automatic int model_victim(input logic [3:0] v, input logic [3:0] l);
    int cand[$];
    for (int w = 0; w < WIDTH; w++) if (v[w] == 1'b0) cand.push_back(w);
    if (cand.size() > 0) return cand[0];
    for (int w = 0; w < WIDTH; w++) if (l[w] == 1'b1) cand.push_back(w);
    if (cand.size() > 0) return cand[0];
    return 0;
  endfunction

  // Hold reset for one edge, then release and follow the whole init sweep.
  task automatic sweep();
    reset = 1'b1;
    tick();
    #1;
    chk("rst_lru_reset", lru_reset, 1);
    chk("rst_lru_index", lru_index, 0);
    chk("rst_miss_ready", miss_ready, 0);
    chk("rst_fill_req", fill_req, 0);
    chk("rst_wb_req", wb_req, 0);
    chk("rst_victim", victim_way, 0);
    reset = 1'b0;
    last_victim = 0;
    for (int k = 0; k < DEPTH; k++) begin
      #1;
      chk("init_index", lru_index, k);
      chk("init_lru_reset", lru_reset, 1);
      chk("init_miss_ready", miss_ready, 0);
      tick();
    end
    #1;
    chk("post_init_miss_ready", miss_ready, 1);
    chk("post_init_lru_reset", lru_reset, 0);
    chk("post_init_index", lru_index, 0);
  endtask

  task automatic do_miss(input logic [3:0] idx, input logic [3:0] v, input logic [3:0] d,
                         input logic [3:0] l, input int wbw, input int flw, input bit with_hit);
    int  vic;
    bit  exp_wb;
    vic    = model_victim(v, l);
    exp_wb = v[vic] && d[vic];
    miss_req   = 1'b1;
    miss_index = idx;
    valid_bits = v;
    dirty_bits = d;
    hit_req    = with_hit;
    hit_index  = 4'($urandom);
    hit_way    = 2'($urandom);
    #1;
    chk("acc_miss_ready", miss_ready, 1);
    if (with_hit) chk("acc_hit_ready_blocked", hit_ready, 0);
    tick();
    miss_req   = 1'b0;
    hit_req    = 1'b0;
    valid_bits = 4'($urandom);
    dirty_bits = 4'($urandom);
    lru_way    = l;
    #1;
    chk("read_index", lru_index, idx);
    chk("read_miss_ready", miss_ready, 0);
    tick();
    #1;
    chk("select_index", lru_index, idx);
    chk("select_wb_req", wb_req, 0);
    chk("select_fill_req", fill_req, 0);
    tick();
    lru_way = 4'($urandom);
    if (exp_wb) begin
      for (int c = 0; c <= wbw; c++) begin
        fill_done = (c < wbw);
        wb_done   = (c == wbw);
        #1;
        chk("wb_req", wb_req, 1);
        chk("wb_way", wb_way, vic);
        chk("wb_fill_req", fill_req, 0);
        tick();
        wb_done   = 1'b0;
        fill_done = 1'b0;
      end
    end else begin
      #1;
      chk("no_wb_req", wb_req, 0);
    end
    for (int c = 0; c <= flw; c++) begin
      wb_done   = (c < flw);
      fill_done = (c == flw);
      #1;
      chk("fill_req", fill_req, 1);
      chk("fill_way", fill_way, vic);
      chk("fill_victim", victim_way, vic);
      tick();
      wb_done   = 1'b0;
      fill_done = 1'b0;
    end
    #1;
    chk("upd_access_valid", lru_access_valid, 1);
    chk("upd_access", lru_access, vic);
    chk("upd_miss_done", miss_done, 1);
    chk("upd_hit_done", hit_done, 0);
    tick();
    #1;
    chk("end_access_valid", lru_access_valid, 0);
    chk("end_miss_done", miss_done, 0);
    chk("end_miss_ready", miss_ready, 1);
    chk("end_victim", victim_way, vic);
    last_victim = vic;
  endtask

  task automatic do_hit(input logic [3:0] idx, input logic [1:0] way);
    miss_req  = 1'b0;
    hit_req   = 1'b1;
    hit_index = idx;
    hit_way   = way;
    #1;
    chk("hit_ready", hit_ready, 1);
    tick();
    hit_req   = 1'b0;
    hit_way   = 2'($urandom);
    #1;
    chk("hit_read_index", lru_index, idx);
    chk("hit_read_access_valid", lru_access_valid, 0);
    tick();
    #1;
    chk("hit_upd_access_valid", lru_access_valid, 1);
    chk("hit_upd_access", lru_access, way);
    chk("hit_upd_hit_done", hit_done, 1);
    chk("hit_upd_miss_done", miss_done, 0);
    chk("hit_upd_victim", victim_way, last_victim);
    tick();
    #1;
    chk("hit_end_ready", miss_ready, 1);
    chk("hit_end_done", hit_done, 0);
  endtask

  initial begin
    reset      = 1'b1;
    miss_req   = 1'b0;
    miss_index = '0;
    valid_bits = '0;
    dirty_bits = '0;
    hit_req    = 1'b0;
    hit_index  = '0;
    hit_way    = '0;
    lru_way    = '0;
    wb_done    = 1'b0;
    fill_done  = 1'b0;

    tick();
    sweep();

    // Invalid way 2 chosen, no writeback, two-cycle fill wait.
    do_miss(4'd5, 4'b1011, 4'b0000, 4'b0001, 0, 2, 1'b0);
    // Dirty LRU victim: three writeback cycles, then fill.
    do_miss(4'd3, 4'hF, 4'b0100, 4'b0100, 2, 1, 1'b0);
    // All valid, zero LRU vector falls back to way 0.
    do_miss(4'd7, 4'hF, 4'b0000, 4'b0000, 0, 0, 1'b0);
    // Multiple LRU bits: lowest wins (way 1), dirty.
    do_miss(4'd12, 4'hF, 4'b0010, 4'b1010, 1, 0, 1'b0);
    // Simultaneous miss and hit: miss wins, hit follows.
    do_miss(4'd9, 4'b0111, 4'b1111, 4'b0001, 0, 1, 1'b1);
    do_hit(4'd9, 2'd1);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 24; n++) begin
      logic [3:0] v, d, l;
      v = 4'($urandom);
      if ($urandom_range(0, 1) == 1) v = 4'hF;
      d = 4'($urandom);
      l = 4'($urandom);
      do_miss(4'($urandom), v, d, l, $urandom_range(0, 3), $urandom_range(0, 3),
              1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) do_hit(4'($urandom), 2'($urandom));
    end

    // Reset in the middle of a fill: handshake drops, sweep restarts at 0.
    miss_req   = 1'b1;
    miss_index = 4'd10;
    valid_bits = 4'hF;
    dirty_bits = 4'h0;
    tick();
    miss_req = 1'b0;
    lru_way  = 4'b0010;
    tick();
    tick();
    #1;
    chk("pre_reset_fill_req", fill_req, 1);
    chk("pre_reset_fill_way", fill_way, 1);
    reset = 1'b1;
    #1;
    chk("reset_now_fill_req", fill_req, 0);
    chk("reset_now_lru_reset", lru_reset, 1);
    sweep();

    do_miss(4'd2, 4'b1110, 4'b1111, 4'b1000, 0, 0, 1'b0);
    do_hit(4'd15, 2'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lru_replacement_controller.md
LRU_REPLACEMENT_CONTROLLER -- requirements
Module: lru_replacement_controller

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the number of ways per set (power of 2, at least 2); WAY_BITS = log2(WIDTH).
REQ-002 SHALL have parameter INDEX_BITS, default 8, giving the set index width; DEPTH = 2^INDEX_BITS.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port miss_req, input, 1 bit: miss request, sampled only when miss_ready=1.
REQ-006 SHALL have port miss_index, input, INDEX_BITS: set index of the miss.
REQ-007 SHALL have port valid_bits, input, WIDTH: valid bit per way of the missing set, sampled with miss_req.
REQ-008 SHALL have port dirty_bits, input, WIDTH: dirty bit per way of the missing set, sampled with miss_req.
REQ-009 SHALL have port miss_ready, output, 1 bit: high when a miss can be accepted.
REQ-010 SHALL have port hit_req, input, 1 bit: hit recency update, sampled only when hit_ready=1.
REQ-011 SHALL have port hit_index, input, INDEX_BITS, and port hit_way, input, WAY_BITS: set and way of the hit.
REQ-012 SHALL have port hit_ready, output, 1 bit: high when a hit update can be accepted.
REQ-013 SHALL have port lru_index, output, INDEX_BITS: drives the current_index input of the LRU tracker.
REQ-014 SHALL have port lru_reset, output, 1 bit: drives the reset input of the LRU tracker (per-set order init).
REQ-015 SHALL have port lru_way, input, WIDTH: one-hot LRU vector from the tracker, valid one cycle after lru_index is presented.
REQ-016 SHALL have ports lru_access, output, WAY_BITS, and lru_access_valid, output, 1 bit: recency update to the tracker.
REQ-017 SHALL have ports wb_req, output, 1 bit, wb_way, output, WAY_BITS, and wb_done, input, 1 bit: writeback handshake.
REQ-018 SHALL have ports fill_req, output, 1 bit, fill_way, output, WAY_BITS, and fill_done, input, 1 bit: refill handshake.
REQ-019 SHALL have ports victim_way, output, WAY_BITS, miss_done, output, 1 bit, and hit_done, output, 1 bit: completion signals.

Function
REQ-020 SHALL implement states INIT, IDLE, READ, SELECT, WRITEBACK, FILL, UPDATE.
REQ-021 SHALL, in INIT: drive lru_reset=1 and lru_index=init_cnt, increment init_cnt each cycle, and move to IDLE after the cycle with init_cnt=DEPTH-1; DEPTH cycles total.
REQ-022 SHALL drive miss_ready=1 only in IDLE.
REQ-023 SHALL drive hit_ready=1 only in IDLE with miss_req=0; miss wins when both are requested in the same cycle.
REQ-024 SHALL, on an accepted miss or hit: latch index, way and bits, set is_hit accordingly, and go to READ.
REQ-025 SHALL, in READ and every later non-INIT state: hold lru_index at the latched index (lru_index=0 in IDLE).
REQ-026 SHALL go from READ to UPDATE if is_hit, else to SELECT.
REQ-027 SHALL, in SELECT, register victim_way as the lowest-numbered way with valid_bits=0 if any exists; else the lowest set bit of lru_way; else way 0 if lru_way=0.
REQ-028 SHALL, from SELECT, go to WRITEBACK if the victim is valid and dirty, else to FILL.
REQ-029 SHALL, in WRITEBACK, hold wb_req=1 and wb_way=victim_way until the cycle wb_done=1, then go to FILL; wb_done outside WRITEBACK is ignored.
REQ-030 SHALL, in FILL, hold fill_req=1 and fill_way=victim_way until the cycle fill_done=1, then go to UPDATE; fill_done outside FILL is ignored.
REQ-031 SHALL, in UPDATE, assert lru_access_valid=1 for exactly one cycle, with lru_access=hit_way (hit) or victim_way (miss).
REQ-032 SHALL, in UPDATE, pulse miss_done or hit_done for that same cycle, then return to IDLE.
REQ-033 SHALL hold victim_way stable from SELECT until the next accepted miss.
REQ-034 SHALL complete a miss with no writeback in 4 cycles plus the fill wait, and a hit in 2 cycles after acceptance.
REQ-035 SHALL keep lru_access_valid, wb_req and fill_req at 0 in all states not named above.

Reset
REQ-036 SHALL, with reset=1 at any cycle including mid-operation: go to INIT with init_cnt=0 and latched fields cleared.
REQ-037 SHALL, while reset=1: hold lru_reset=1, lru_index=0, and all other outputs at 0.
REQ-038 SHALL, after reset deasserts, run the full DEPTH-cycle sweep; miss_ready first rises DEPTH cycles after deassertion.

Verification (WIDTH=4, INDEX_BITS=4)
REQ-039 SHALL be verified by: release reset -> lru_reset=1 with lru_index 0..15 on consecutive cycles, then miss_ready=1 on cycle 16.
REQ-040 SHALL be verified by: miss index 5, valid=4'b1011, dirty=0 -> victim_way=2, no wb_req, fill_req until fill_done, one lru_access_valid with lru_access=2, miss_done.
REQ-041 SHALL be verified by: miss index 3, valid=4'hF, dirty=4'b0100, lru_way=4'b0100 -> wb_req with wb_way=2 held 3 cycles until wb_done, then fill_req with fill_way=2.
REQ-042 SHALL be verified by: miss_req and hit_req in the same IDLE cycle -> miss accepted, hit_ready=0; hit accepted after miss_done, yielding lru_access=hit_way and hit_done 2 cycles later.
REQ-043 SHALL be verified by: reset asserted during FILL -> next cycle fill_req=0 and lru_reset=1; sweep restarts at index 0.
REQ-044 SHALL be verified by: valid=4'hF and lru_way=0 -> victim_way=0.
